// File: rtl/rob_completion_tracker.sv
// 32-entry reorder-buffer tracker: marks entries done/faulted from the writeback
// ports, retires up to two per cycle in order from the head, and flags a head trap.
module rob_completion_tracker (
  input  logic       cpu_clock_i,
  input  logic       cpu_reset_i,
  input  logic       flush_i,
  input  logic [1:0] alloc_req_i,
  output logic       alloc_ready_o,
  output logic [4:0] alloc_id_o,
  input  logic [4:0] ins_completed,
  input  logic       ins_cmp_v,
  input  logic [5:0] excp_rob,
  input  logic [4:0] excp_code,
  input  logic       excp_valid,
  output logic [1:0] commit_valid_o,
  output logic [4:0] commit_id_o,
  output logic       trap_valid_o,
  output logic [4:0] trap_id_o,
  output logic [4:0] trap_code_o,
  output logic [5:0] count_o
);

  logic [31:0] valid_r;
  logic [31:0] done_r;
  logic [31:0] excp_r;
  logic [4:0]  code_r [32];
  logic [4:0]  head_r;
  logic [4:0]  tail_r;
  logic [5:0]  count_r;

  logic [4:0]  head1_s;
  logic [4:0]  tail1_s;
  logic        c0_s;
  logic        c1_s;
  logic        trap_s;
  logic        ready_s;
  logic [1:0]  alloc_n_s;
  logic [1:0]  retire_n_s;

  // Commit, trap and allocation decisions, all from registered state.
  always_comb begin
    head1_s    = head_r + 5'd1;
    tail1_s    = tail_r + 5'd1;
    c0_s       = valid_r[head_r] & done_r[head_r] & ~excp_r[head_r];
    c1_s       = c0_s & valid_r[head1_s] & done_r[head1_s] & ~excp_r[head1_s];
    trap_s     = valid_r[head_r] & done_r[head_r] & excp_r[head_r];
    ready_s    = (count_r <= 6'd30);
    retire_n_s = {1'b0, c0_s} + {1'b0, c1_s};
    if (ready_s && ((alloc_req_i == 2'd1) || (alloc_req_i == 2'd2))) begin
      alloc_n_s = alloc_req_i;
    end else begin
      alloc_n_s = 2'd0;
    end
  end

  // Per-entry state and pointer update; reset and flush override every input.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || flush_i) begin
      valid_r <= 32'd0;
      done_r  <= 32'd0;
      excp_r  <= 32'd0;
      head_r  <= 5'd0;
      tail_r  <= 5'd0;
      count_r <= 6'd0;
      for (int i = 0; i < 32; i++) begin
        code_r[i] <= 5'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        // Retired slots are never the ones being allocated while count <= 30.
        if ((c0_s && (head_r == 5'(i))) || (c1_s && (head1_s == 5'(i)))) begin
          valid_r[i] <= 1'b0;
        end
        if (((alloc_n_s != 2'd0) && (tail_r == 5'(i))) ||
            ((alloc_n_s == 2'd2) && (tail1_s == 5'(i)))) begin
          valid_r[i] <= 1'b1;
          done_r[i]  <= 1'b0;
          excp_r[i]  <= 1'b0;
        end
        if (ins_cmp_v && valid_r[i] && (ins_completed == 5'(i))) begin
          done_r[i] <= 1'b1;
        end
        if (excp_valid && valid_r[i] && (excp_rob[4:0] == 5'(i))) begin
          done_r[i] <= 1'b1;
          excp_r[i] <= 1'b1;
          code_r[i] <= excp_code;
        end
      end
      head_r  <= head_r + {3'd0, retire_n_s};
      tail_r  <= tail_r + {3'd0, alloc_n_s};
      count_r <= count_r + {4'd0, alloc_n_s} - {4'd0, retire_n_s};
    end
  end

  assign alloc_ready_o  = ready_s;
  assign alloc_id_o     = tail_r;
  assign commit_valid_o = {c1_s, c0_s};
  assign commit_id_o    = head_r;
  assign trap_valid_o   = trap_s;
  assign trap_id_o      = trap_s ? head_r : 5'd0;
  assign trap_code_o    = trap_s ? code_r[head_r] : 5'd0;
  assign count_o        = count_r;

endmodule
